// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential fetch, prioritised redirects with a flush
// bubble window, jump-and-link write-back and halt. Optional PC_REDIRECT_COUNT_EN adds redirect_cnt.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [3:0]  LINK_REG     = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        imem_rdy,
  input  logic        br_valid,
  input  logic [15:0] br_target,
  input  logic        jal_valid,
  input  logic [15:0] jal_target,
  input  logic [15:0] jal_ret,
  input  logic        jr_valid,
  input  logic [15:0] jr_target,
  input  logic        hlt_req,
  output logic [15:0] pc,
  output logic        imem_req,
  output logic        flush,
  output logic        link_we,
  output logic [3:0]  link_addr,
  output logic [15:0] link_data,
  output logic        halted
`ifdef PC_REDIRECT_COUNT_EN
  ,
  output logic [15:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_JR, SRC_JAL, SRC_BR} src_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  cnt;
  src_t        src;
  logic [15:0] tgt;
  logic        hlt_take;
  logic        redir_take;

  assign link_addr = LINK_REG;

  // Priority select among the jump sources; halt is handled separately.
  always_comb begin
    src = SRC_NONE;
    tgt = '0;
    if (jr_valid) begin
      src = SRC_JR;
      tgt = {jr_target[15:1], 1'b0};
    end else if (jal_valid) begin
      src = SRC_JAL;
      tgt = {jal_target[15:1], 1'b0};
    end else if (br_valid) begin
      src = SRC_BR;
      tgt = {br_target[15:1], 1'b0};
    end
  end

  assign hlt_take   = (state != HALTED) && hlt_req;
  assign redir_take = (state != HALTED) && !hlt_req && (src != SRC_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      flush     <= 1'b0;
      link_we   <= 1'b0;
      link_data <= '0;
      halted    <= 1'b0;
    end else begin
      flush   <= 1'b0;
      link_we <= 1'b0;
      if (hlt_take) begin
        state    <= HALTED;
        cnt      <= '0;
        imem_req <= 1'b0;
        flush    <= 1'b1;
        halted   <= 1'b1;
      end else if (redir_take) begin
        state    <= FLUSH;
        cnt      <= '0;
        pc       <= tgt;
        imem_req <= 1'b0;
        flush    <= 1'b1;
        if (src == SRC_JAL) begin
          link_we   <= 1'b1;
          link_data <= jal_ret;
        end
      end else begin
        case (state)
          RUN: begin
            // imem_req is low only in the first cycle out of reset, so no advance then.
            imem_req <= 1'b1;
            if (!stall && imem_req && imem_rdy)
              pc <= pc + 16'd2;
          end
          FLUSH: begin
            if (!stall) begin
              if (cnt == FLUSH_LAST) begin
                state    <= RUN;
                cnt      <= '0;
                imem_req <= 1'b1;
              end else begin
                cnt <= cnt + 3'd1;
              end
            end
          end
          HALTED: begin
            imem_req <= 1'b0;
          end
          default: begin
            state    <= RUN;
            cnt      <= '0;
            imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PC_REDIRECT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      redirect_cnt <= '0;
    else if (redir_take && (redirect_cnt != '1))
      redirect_cnt <= redirect_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared against a bubble-counting reference model.
module tb_pc_sequencer;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, imem_rdy, br_valid, jal_valid, jr_valid, hlt_req;
  logic [15:0] br_target, jal_target, jal_ret, jr_target;
  logic [15:0] pc, link_data;
  logic        imem_req, flush, link_we, halted;
  logic [3:0]  link_addr;
`ifdef PC_REDIRECT_COUNT_EN
  logic [15:0] redirect_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [15:0] m_pc, m_ldata;
  logic        m_req, m_flush, m_lwe, m_halt;
  int          m_bub;
  int          m_rcnt;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC    (16'h0000),
    .FLUSH_CYCLES(FC),
    .LINK_REG    (4'hF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .imem_rdy  (imem_rdy),
    .br_valid  (br_valid),
    .br_target (br_target),
    .jal_valid (jal_valid),
    .jal_target(jal_target),
    .jal_ret   (jal_ret),
    .jr_valid  (jr_valid),
    .jr_target (jr_target),
    .hlt_req   (hlt_req),
    .pc        (pc),
    .imem_req  (imem_req),
    .flush     (flush),
    .link_we   (link_we),
    .link_addr (link_addr),
    .link_data (link_data),
    .halted    (halted)
`ifdef PC_REDIRECT_COUNT_EN
    ,
    .redirect_cnt(redirect_cnt)
`endif
  );

  function automatic logic [39:0] act_vec();
    return {pc, imem_req, flush, link_we, link_addr, link_data, halted};
  endfunction

  function automatic logic [39:0] exp_vec();
    return {m_pc, m_req, m_flush, m_lwe, 4'hF, m_ldata, m_halt};
  endfunction

  task automatic clear_inputs();
    stall = 0; imem_rdy = 0; br_valid = 0; jal_valid = 0; jr_valid = 0; hlt_req = 0;
    br_target = '0; jal_target = '0; jal_ret = '0; jr_target = '0;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ldata = '0; m_req = 0; m_flush = 0; m_lwe = 0; m_halt = 0;
    m_bub = 0; m_rcnt = 0;
  endtask

  // One clock of architectural behaviour: a redirect opens FC bubble cycles,
  // each unstalled cycle consumes one, fetch is requested when none remain.
  task automatic model_step();
    if (m_halt) begin
      m_flush = 0; m_lwe = 0; m_req = 0;
    end else if (hlt_req) begin
      m_halt = 1; m_flush = 1; m_lwe = 0; m_req = 0;
    end else if (jr_valid || jal_valid || br_valid) begin
      m_pc = jr_valid ? jr_target : (jal_valid ? jal_target : br_target);
      m_pc[0] = 1'b0;
      m_lwe = !jr_valid && jal_valid;
      if (m_lwe) m_ldata = jal_ret;
      m_flush = 1; m_bub = FC; m_req = 0;
      if (m_rcnt < 65535) m_rcnt++;
    end else begin
      m_flush = 0; m_lwe = 0;
      if (!stall) begin
        if (m_req && imem_rdy) m_pc = m_pc + 16'd2;
        if (m_bub > 0) m_bub--;
      end
      m_req = (m_bub == 0);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    imem_rdy = 1;
    rst_n = 0;
    model_reset();
    #2;
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_async: got %h expected %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_hold%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    @(negedge clk);
    rst_n = 1;
    cycle();
    n_checks++;
    if (pc !== 16'h0000 || imem_req !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_first_fetch: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_sequential();
    imem_rdy = 1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_checks++;
      if (pc !== 16'(2 * i) || act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL seq_pc%0d: got %h expected %h (pc %h)", i, act_vec(), exp_vec(), 16'(2 * i));
      end
    end
  endtask

  task automatic test_branch();
    int bubbles;
    imem_rdy = 1;
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (pc !== 16'h0010) begin
      n_fail++; $display("FAIL br_setup_pc: got %h expected 0010", pc);
    end
    br_valid = 1; br_target = 16'h0040;
    cycle();
    br_valid = 0;
    n_checks++;
    if (flush !== 1'b1 || pc !== 16'h0040 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL br_redirect: got %h expected %h", act_vec(), exp_vec());
    end
    bubbles = (imem_req == 1'b0) ? 1 : 0;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) begin
      cycle();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL br_flush_cyc%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (imem_req == 1'b0) bubbles++;
    end
    n_checks++;
    if (bubbles !== 2 || pc !== 16'h0040 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL br_bubbles: got %0d bubbles pc %h, expected 2 bubbles pc 0040", bubbles, pc);
    end
  endtask

  task automatic test_jal_priority();
    imem_rdy = 1;
    jal_valid = 1; jal_target = 16'h0100; jal_ret = 16'h0022;
    br_valid = 1; br_target = 16'h0300;
    cycle();
    jal_valid = 0; br_valid = 0;
    n_checks++;
    if (pc !== 16'h0100 || link_we !== 1'b1 || link_addr !== 4'hF || link_data !== 16'h0022
        || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL jal_link: got %h expected %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (link_we !== 1'b0 || act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL jal_after%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_flush_restart();
    int bubbles;
    imem_rdy = 1;
    br_valid = 1; br_target = 16'h0080;
    cycle();
    br_target = 16'h0200;
    cycle();
    br_valid = 0;
    n_checks++;
    if (pc !== 16'h0200 || flush !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL restart_redirect: got %h expected %h", act_vec(), exp_vec());
    end
    bubbles = 2;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) begin
      cycle();
      if (imem_req == 1'b0) bubbles++;
    end
    n_checks++;
    if (bubbles !== 3 || pc !== 16'h0200 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL restart_bubbles: got %0d pc %h, expected 3 pc 0200", bubbles, pc);
    end
  endtask

  task automatic test_wrap_stall();
    imem_rdy = 1;
    jr_valid = 1; jr_target = 16'hFFFF;
    cycle();
    jr_valid = 0;
    n_checks++;
    if (pc !== 16'hFFFE) begin
      n_fail++; $display("FAIL jr_bit0: got %h expected fffe", pc);
    end
    for (int i = 0; i < FC; i++) cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (pc !== 16'hFFFE || imem_req !== 1'b1 || act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    stall = 0;
    cycle();
    n_checks++;
    if (pc !== 16'h0000 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL pc_wrap: got %h expected 0000", pc);
    end
    stall = 1; br_valid = 1; br_target = 16'h1234;
    cycle();
    br_valid = 0;
    n_checks++;
    if (pc !== 16'h1234 || flush !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL stall_override: got %h expected %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (imem_req !== 1'b0 || act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stall_in_flush%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    stall = 0;
    for (int i = 0; i < FC; i++) cycle();
    n_checks++;
    if (imem_req !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL stall_flush_exit: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall      = ($urandom_range(0, 4) == 0);
      imem_rdy   = ($urandom_range(0, 9) < 7);
      jr_valid   = ($urandom_range(0, 11) == 0);
      jal_valid  = ($urandom_range(0, 9) == 0);
      br_valid   = ($urandom_range(0, 7) == 0);
      jr_target  = 16'($urandom);
      jal_target = 16'($urandom);
      jal_ret    = 16'($urandom);
      br_target  = 16'($urandom);
      cycle();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rand%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
`ifdef PC_REDIRECT_COUNT_EN
      n_checks++;
      if (redirect_cnt !== 16'(m_rcnt)) begin
        n_fail++; $display("FAIL rand_cnt%0d: got %0d expected %0d", i, redirect_cnt, m_rcnt);
      end
`endif
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_flush();
    imem_rdy = 1;
    br_valid = 1; br_target = 16'h0ABC;
    cycle();
    br_valid = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_mid_flush: got %h expected %h", act_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1;
    cycle();
    cycle();
    n_checks++;
    if (pc !== 16'h0002 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_mid_flush_fetch: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_halt();
    logic [15:0] frozen;
    imem_rdy = 1;
    cycle();
    frozen = pc;
    hlt_req = 1; jr_valid = 1; jr_target = 16'h0600; jal_valid = 1; jal_ret = 16'h7777;
    cycle();
    hlt_req = 0; jr_valid = 0; jal_valid = 0;
    n_checks++;
    if (halted !== 1'b1 || flush !== 1'b1 || pc !== frozen || link_we !== 1'b0
        || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL halt_enter: got %h expected %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 20; i++) begin
      br_valid = $urandom_range(0, 1); br_target = 16'($urandom);
      jal_valid = $urandom_range(0, 1); jal_target = 16'($urandom);
      hlt_req = $urandom_range(0, 1);
      cycle();
      n_checks++;
      if (halted !== 1'b1 || pc !== frozen || flush !== 1'b0 || act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL halt_hold%0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    clear_inputs();
    imem_rdy = 1;
    #1;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (halted !== 1'b0 || pc !== 16'h0000 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL halt_reset: got %h expected %h", act_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1;
    cycle();
    n_checks++;
    if (imem_req !== 1'b1 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL halt_restart: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jal_priority();
    test_flush_restart();
    test_wrap_stall();
    test_random();
    test_reset_mid_flush();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: bubble cycles after any redirect, legal range 1..7.
REQ-003 SHALL have parameter LINK_REG, default 4'hF: register-file address written by jump-and-link.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port stall, input, 1: hold PC and state; no fetch advance.
REQ-007 SHALL have port imem_rdy, input, 1: instruction memory accepts the request this cycle.
REQ-008 SHALL have port br_valid, input, 1: branch resolved taken (execBranch) this cycle.
REQ-009 SHALL have port br_target, input, 16: branch destination PC.
REQ-010 SHALL have port jal_valid, input, 1: jump-and-link executing this cycle.
REQ-011 SHALL have port jal_target, input, 16: jump-and-link destination PC.
REQ-012 SHALL have port jal_ret, input, 16: return address to link.
REQ-013 SHALL have port jr_valid, input, 1: jump-register executing this cycle.
REQ-014 SHALL have port jr_target, input, 16: register-sourced destination PC.
REQ-015 SHALL have port hlt_req, input, 1: halt instruction reached execute.
REQ-016 SHALL have port pc, output, 16: current fetch address.
REQ-017 SHALL have port imem_req, output, 1: fetch request valid.
REQ-018 SHALL have port flush, output, 1: kill younger in-flight instructions.
REQ-019 SHALL have port link_we, output, 1: register-file write enable for the link.
REQ-020 SHALL have ports link_addr, output, 4, and link_data, output, 16: link write address (LINK_REG) and data.
REQ-021 SHALL have port halted, output, 1: sequencer stopped; register dump may proceed.

Function
REQ-022 SHALL implement states RUN, FLUSH, HALTED.
REQ-023 In RUN, imem_req SHALL be 1; pc SHALL advance by 2 when imem_rdy=1, stall=0, and no redirect is pending.
REQ-024 Redirect priority SHALL be hlt_req > jr_valid > jal_valid > br_valid; lower-priority requests in the same cycle SHALL be ignored.
REQ-025 On an accepted redirect, pc SHALL load the winning target on the next edge, flush SHALL be 1 for that same cycle, and state SHALL go to FLUSH.
REQ-026 In FLUSH, imem_req SHALL be 0; a 3-bit counter SHALL count FLUSH_CYCLES-1 further cycles, then state returns to RUN.
REQ-027 A redirect arriving in FLUSH SHALL be accepted, load its target, and restart the counter.
REQ-028 An accepted jal SHALL pulse link_we for exactly one cycle with link_addr=LINK_REG and link_data=jal_ret captured that cycle.
REQ-029 An accepted hlt_req SHALL assert flush for one cycle, freeze pc, enter HALTED, and set halted=1; HALTED SHALL be exited only by reset.
REQ-030 stall=1 SHALL freeze pc, state and counter; redirects SHALL override stall.
REQ-031 PC arithmetic SHALL be 16-bit modulo: 16'hFFFE+2 wraps to 16'h0000.
REQ-032 Targets SHALL be used as given; bit 0 SHALL be forced to 0.

Reset
REQ-033 While rst_n=0: pc=RESET_PC, state=RUN, counter=0, imem_req=0, flush=0, link_we=0, link_data=0, halted=0.
REQ-034 Reset asserted mid-FLUSH or in HALTED SHALL abort immediately; the first fetch occurs in the first cycle after deassertion.

Configuration
REQ-035 With macro PC_REDIRECT_COUNT_EN defined, SHALL add output redirect_cnt[15:0], which counts accepted jr/jal/br redirects, saturates at 16'hFFFF, and resets to 0; when undefined, the port and counter SHALL be absent with no other behaviour change.

Verification
REQ-036 Reset release, imem_rdy=1 for 4 cycles -> pc sequence 0000, 0002, 0004, 0006, 0008.
REQ-037 br_valid with br_target=0x0040 at pc=0x0010 -> flush=1 for one cycle, imem_req=0 for 2 cycles, fetch resumes at 0x0040.
REQ-038 jal_valid (jal_target=0x0100, jal_ret=0x0022) together with br_valid -> pc=0x0100, one link_we pulse with link_addr=F and link_data=0x0022, branch ignored.
REQ-039 hlt_req with jr_valid -> halted=1, pc frozen, no link write, stays halted for 20 cycles, cleared only by rst_n.
REQ-040 pc=0xFFFE with imem_rdy=1 -> next pc=0x0000; stall=1 for 3 cycles -> pc unchanged.
REQ-041 Second br_valid (target 0x0200) during FLUSH -> pc=0x0200, counter restarts, total bubbles = 1 + 2.
